// File: rtl/ram_serv_pkg.sv
// ram_serv_pkg: shared channel state type and elaboration helpers for the frame RAM sequencer
package ram_serv_pkg;
  typedef enum logic [1:0] {IDLE, ARM, HOLD} srv_state_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic bit fits(longint v, int w);
    return v <= (longint'(1) << w);
  endfunction
endpackage

// File: rtl/ram_serv_seq_if.sv
// ram_serv_seq_if: frame RAM sequencer bus, master drives frame/request inputs
interface ram_serv_seq_if #(parameter int ADDR_W = 8, DATA_W = 8, N_SRV = 3);
  logic fs, start, we, frame_done, rd_ovf;
  logic [DATA_W-1:0] in_data, out_data;
  logic [N_SRV-1:0] srv_req, srv_out;
  logic [ADDR_W-1:0] adr_wr, adr_rd;
  modport master (output fs, start, in_data, srv_req,
                  input out_data, we, adr_wr, adr_rd, srv_out, frame_done, rd_ovf);
  modport slave (input fs, start, in_data, srv_req,
                 output out_data, we, adr_wr, adr_rd, srv_out, frame_done, rd_ovf);
endinterface

// File: rtl/srv_stretch.sv
// srv_stretch: one service channel, arm delay after the last request then a stretched hold with write window
module srv_stretch import ram_serv_pkg::*; #(
  parameter int DLY_ARM = 10, DLY_HOLD = 20000, WE_GUARD = 100, CNT_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic srv_out,
  output logic win
);
  localparam logic [CNT_W-1:0] ARM_END = CNT_W'(DLY_ARM);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(DLY_HOLD - 1);
  localparam logic [CNT_W-1:0] WIN_END = CNT_W'(DLY_HOLD - WE_GUARD);
  srv_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req) state_nxt = ARM;
      end
      ARM:
        if (req) cnt_nxt = '0;
        else if (cnt == ARM_END) begin
          state_nxt = HOLD;
          cnt_nxt = '0;
        end
      HOLD:
        if (cnt == HOLD_END) begin
          state_nxt = IDLE;
          cnt_nxt = '0;
        end
      default: begin
        state_nxt = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end
  always_comb begin
    srv_out = state == HOLD;
    win = srv_out && cnt < WIN_END;
  end
endmodule

// File: rtl/ram_serv_seq.sv
// ram_serv_seq: frame RAM write address/strobe sequencer with service slots and start-stepped read pointer
module ram_serv_seq import ram_serv_pkg::*; #(
  parameter int ADDR_W = 8, DATA_W = 8, FRAME_LEN = 20, N_SRV = 3,
  parameter int DLY_ARM = 10, DLY_HOLD = 20000, WE_GUARD = 100, CNT_W = 16
) (
  input logic clk,
  input logic reset,
  ram_serv_seq_if.slave bus
);
  localparam int IDX_W = idx_w(N_SRV);
  localparam logic [ADDR_W-1:0] DATA_LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(FRAME_LEN + N_SRV - 1);
  localparam logic [ADDR_W-1:0] SRV_BASE = ADDR_W'(FRAME_LEN);
  if (!fits(FRAME_LEN + N_SRV, ADDR_W)) begin : g_chk_addr
    $error("FRAME_LEN+N_SRV does not fit in ADDR_W");
  end
  if (WE_GUARD >= DLY_HOLD) begin : g_chk_guard
    $error("WE_GUARD must be below DLY_HOLD");
  end
  if (!fits(longint'(DLY_HOLD) + 1, CNT_W)) begin : g_chk_cnt
    $error("DLY_HOLD does not fit in CNT_W");
  end
  logic [N_SRV-1:0] win, srv_out;
  logic [IDX_W-1:0] sel;
  logic [ADDR_W-1:0] adr_wr, adr_rd;
  logic [DATA_W-1:0] data_q;
  logic [3:0] st_sync;
  logic we, frame_done, rd_ovf, rd_step;
  for (genvar i = 0; i < N_SRV; i++) begin : g_ch
    srv_stretch #(.DLY_ARM(DLY_ARM), .DLY_HOLD(DLY_HOLD), .WE_GUARD(WE_GUARD), .CNT_W(CNT_W)) u_ch (
      .clk(clk), .reset(reset), .req(bus.srv_req[i]), .srv_out(srv_out[i]), .win(win[i])
    );
  end
  always_comb begin
    sel = '0;
    for (int i = N_SRV - 1; i >= 0; i--) if (win[i]) sel = IDX_W'(i);
  end
  // three synchroniser stages feed st_sync[2]; st_sync[3] is the edge reference
  assign rd_step = st_sync[2] & ~st_sync[3];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      adr_wr <= '0;
      we <= 1'b0;
      frame_done <= 1'b0;
      data_q <= '0;
    end else begin
      data_q <= bus.in_data;
      frame_done <= adr_wr == DATA_LAST && (bus.fs || !(|win));
      if (bus.fs) begin
        adr_wr <= '0;
        we <= 1'b0;
      end else if (|win) begin
        adr_wr <= SRV_BASE + ADDR_W'(sel);
        we <= 1'b1;
      end else begin
        adr_wr <= adr_wr < DATA_LAST ? adr_wr + ADDR_W'(1) : '0;
        we <= 1'b0;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_sync <= '0;
      adr_rd <= '0;
      rd_ovf <= 1'b0;
    end else begin
      st_sync <= {st_sync[2:0], bus.start};
      if (rd_step) begin
        adr_rd <= adr_rd == RD_LAST ? '0 : adr_rd + ADDR_W'(1);
        if (adr_rd == RD_LAST) rd_ovf <= 1'b1;
      end else if (bus.fs) begin
        adr_rd <= '0;
        rd_ovf <= 1'b0;
      end
    end
  assign bus.adr_wr = adr_wr;
  assign bus.we = we;
  assign bus.frame_done = frame_done;
  assign bus.out_data = data_q;
  assign bus.srv_out = srv_out;
  assign bus.adr_rd = adr_rd;
  assign bus.rd_ovf = rd_ovf;
endmodule

// File: tb/tb_ram_serv_seq.sv
// tb_ram_serv_seq: directed and random stimulus checked each cycle against a timeline-based reference model
module tb_ram_serv_seq;
  localparam int ADDR_W = 8, DATA_W = 8, FRAME_LEN = 20, N_SRV = 3;
  localparam int DLY_ARM = 10, DLY_HOLD = 200, WE_GUARD = 10, CNT_W = 16;
  localparam int RD_TOP = FRAME_LEN + N_SRV - 1;
  logic clk = 0, reset = 0;
  int n_cmp = 0, n_bad = 0;
  ram_serv_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SRV(N_SRV)) bus();
  ram_serv_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .N_SRV(N_SRV),
                 .DLY_ARM(DLY_ARM), .DLY_HOLD(DLY_HOLD), .WE_GUARD(WE_GUARD), .CNT_W(CNT_W))
    dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // model: edge counter, per-channel pending request edge and hold start edge
  int t = 0, rst_t = 0;
  int pend[N_SRV], hstart[N_SRV];
  bit smp[0:19999];
  int m_adr, m_rd;
  bit m_we, m_fd, m_ovf;
  logic [N_SRV-1:0] m_srv, m_winv;
  logic [DATA_W-1:0] m_data;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask
  function automatic bit s_at(int e);
    return e > rst_t ? smp[e] : 1'b0;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N_SRV; i++) begin
      pend[i] = -1;
      hstart[i] = -1;
    end
    m_adr = 0; m_rd = 0; m_we = 0; m_fd = 0; m_ovf = 0;
    m_srv = '0; m_winv = '0; m_data = '0; rst_t = t;
  endtask
  task automatic model_edge();
    int nxt, sel;
    bit rise;
    t++;
    smp[t] = bus.start;
    m_data = bus.in_data;
    if (bus.fs) begin
      nxt = 0; m_we = 0;
    end else if (m_winv != 0) begin
      sel = 0;
      while (!m_winv[sel]) sel++;
      nxt = FRAME_LEN + sel; m_we = 1;
    end else begin
      nxt = m_adr < FRAME_LEN - 1 ? m_adr + 1 : 0; m_we = 0;
    end
    m_fd = m_adr == FRAME_LEN - 1 && nxt == 0;
    m_adr = nxt;
    for (int i = 0; i < N_SRV; i++) begin
      if (!m_srv[i]) begin
        if (bus.srv_req[i]) pend[i] = t;
        else if (pend[i] >= 0 && t == pend[i] + DLY_ARM + 1) begin
          hstart[i] = t;
          pend[i] = -1;
        end
      end
      m_srv[i] = hstart[i] >= 0 && t >= hstart[i] && t < hstart[i] + DLY_HOLD;
      m_winv[i] = hstart[i] >= 0 && t >= hstart[i] && t < hstart[i] + DLY_HOLD - WE_GUARD;
    end
    rise = s_at(t - 3) && !s_at(t - 4);
    if (rise) begin
      if (m_rd == RD_TOP) begin
        m_rd = 0; m_ovf = 1;
      end else m_rd++;
    end else if (bus.fs) begin
      m_rd = 0; m_ovf = 0;
    end
  endtask
  task automatic check_all();
    check("adr_wr", bus.adr_wr, m_adr);
    check("we", bus.we, m_we);
    check("frame_done", bus.frame_done, m_fd);
    check("adr_rd", bus.adr_rd, m_rd);
    check("rd_ovf", bus.rd_ovf, m_ovf);
    check("srv_out", bus.srv_out, m_srv);
    check("out_data", bus.out_data, m_data);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_adr_wr"}, bus.adr_wr, 0);
    check({tag, "_we"}, bus.we, 0);
    check({tag, "_adr_rd"}, bus.adr_rd, 0);
    check({tag, "_rd_ovf"}, bus.rd_ovf, 0);
    check({tag, "_srv_out"}, bus.srv_out, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
  endtask
  task automatic cycle(input logic fs, input logic st, input logic [N_SRV-1:0] req);
    bus.fs = fs; bus.start = st; bus.srv_req = req; bus.in_data = DATA_W'($urandom);
    @(posedge clk);
    #1;
    if (!reset) begin
      model_edge();
      check_all();
    end
  endtask
  int fd_cnt;
  initial begin
    int hi_left, lo_cnt;
    logic st;
    logic [N_SRV-1:0] req;
    int rq_left[N_SRV];
    bus.fs = 0; bus.start = 0; bus.srv_req = '0; bus.in_data = '0;
    #1 reset = 1;
    #2 check_zero("por");
    model_reset();
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    reset = 0;
    fd_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      cycle(0, 0, '0);
      fd_cnt += bus.frame_done;
      if (n == 24) check("idle_adr_wr", bus.adr_wr, 5);
    end
    check("idle_frame_count", fd_cnt, 3);
    check("idle_adr_rd", bus.adr_rd, 0);
    cycle(0, 0, 3'b001);
    for (int n = 0; n < 4; n++) cycle(0, 0, '0);
    cycle(0, 0, 3'b001);
    for (int n = 0; n < 30; n++) cycle(0, 0, '0);
    check("arm_restart_srv", bus.srv_out, 3'b001);
    cycle(1, 0, '0);
    check("fs_win_adr", bus.adr_wr, 0);
    check("fs_win_we", bus.we, 0);
    cycle(0, 0, '0);
    check("after_fs_adr", bus.adr_wr, FRAME_LEN);
    check("after_fs_we", bus.we, 1);
    for (int n = 0; n < 12; n++) cycle(0, 0, '0);
    cycle(0, 0, 3'b100);
    for (int n = 0; n < 400; n++) cycle(0, 0, '0);
    for (int p = 0; p < 23; p++) begin
      cycle(0, 1, '0);
      cycle(0, 0, '0);
      cycle(0, 0, '0);
      cycle(0, 0, '0);
      if (p == 2) check("rd_three", bus.adr_rd, 3);
    end
    check("rd_wrap_adr", bus.adr_rd, 0);
    check("rd_wrap_ovf", bus.rd_ovf, 1);
    cycle(1, 0, '0);
    check("fs_clr_ovf", bus.rd_ovf, 0);
    cycle(0, 0, '0);
    cycle(0, 1, '0);
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    cycle(1, 0, '0);
    check("edge_beats_fs", bus.adr_rd, 1);
    hi_left = 0; lo_cnt = 2;
    for (int i = 0; i < N_SRV; i++) rq_left[i] = 0;
    for (int n = 0; n < 4000; n++) begin
      if (hi_left > 0) begin
        st = 1; hi_left--;
      end else if (lo_cnt >= 2 && $urandom_range(0, 9) == 0) begin
        st = 1; hi_left = $urandom_range(0, 2);
      end else st = 0;
      lo_cnt = st ? 0 : lo_cnt + 1;
      for (int i = 0; i < N_SRV; i++) begin
        if (rq_left[i] > 0) begin
          req[i] = 1; rq_left[i]--;
        end else if ($urandom_range(0, 199) == 0) begin
          req[i] = 1; rq_left[i] = $urandom_range(0, 3);
        end else req[i] = 0;
      end
      cycle($urandom_range(0, 79) == 0, st, req);
    end
    for (int n = 0; n < 300; n++) cycle(0, 0, '0);
    cycle(0, 0, 3'b010);
    for (int n = 0; n < 40; n++) cycle(0, 0, '0);
    check("pre_rst_srv", bus.srv_out, 3'b010);
    #2 reset = 1;
    #1 check_zero("async_rst");
    model_reset();
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    reset = 0;
    for (int n = 0; n < 300; n++) cycle(0, 0, '0);
    check("post_rst_srv", bus.srv_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
